// File: rtl/gf81_pkg.sv
// Shared definitions for the 81-bit GF(2^m) Karatsuba front end.
//   W/LIMB/PW   operand, limb and limb-product widths
//   state_t     control FSM encoding
//   P_*         issue index of each of the six limb products
//   mul_req_t   one request (x, y) to the shared limb multiplier
package gf81_pkg;
    localparam int W     = 81;
    localparam int LIMB  = 27;
    localparam int PW    = 2*LIMB - 1;
    localparam int NPROD = 6;

    localparam logic [2:0] CNT_MAX = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] P_A0B0   = 3'd0;
    localparam logic [2:0] P_A1B1   = 3'd1;
    localparam logic [2:0] P_A2B2   = 3'd2;
    localparam logic [2:0] P_A01B01 = 3'd3;
    localparam logic [2:0] P_A02B02 = 3'd4;
    localparam logic [2:0] P_A12B12 = 3'd5;

    typedef struct packed {
        logic [LIMB-1:0] x;
        logic [LIMB-1:0] y;
    } mul_req_t;
endpackage

// File: rtl/gf81_karatsuba_split_if.sv
// Bus bundle for gf81_karatsuba_split.
//   start/a/b            operand accept
//   busy/done            operation status
//   mul_valid/ready/x/y  request channel to the shared 27x27 carry-less multiplier
//   res_valid/res        in-order result channel from that multiplier
//   p0..p5               collected limb products
// slave = the split block, master = its environment.
interface gf81_karatsuba_split_if;
    import gf81_pkg::*;

    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            mul_valid;
    logic            mul_ready;
    logic [LIMB-1:0] mul_x;
    logic [LIMB-1:0] mul_y;
    logic            res_valid;
    logic [PW-1:0]   res;
    logic [PW-1:0]   p0, p1, p2, p3, p4, p5;
    logic            done;

    modport slave (
        input  start, a, b, mul_ready, res_valid, res,
        output busy, mul_valid, mul_x, mul_y, p0, p1, p2, p3, p4, p5, done
    );

    modport master (
        output start, a, b, mul_ready, res_valid, res,
        input  busy, mul_valid, mul_x, mul_y, p0, p1, p2, p3, p4, p5, done
    );
endinterface

// File: rtl/gf81_limb_sel.sv
// Limb operand mux: picks the (x, y) limb pair for product index idx from the
// latched operands. Indices 3..5 are the GF(2) pair sums (plain XOR).
//   idx  product index 0..5; anything else yields zeros
//   a, b latched 81-bit operands
//   req  limb pair for the shared multiplier
module gf81_limb_sel
    import gf81_pkg::*;
(
    input  logic [2:0]   idx,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output mul_req_t     req
);
    logic [LIMB-1:0] a0, a1, a2, b0, b1, b2;

    assign a0 = a[LIMB-1:0];
    assign a1 = a[2*LIMB-1:LIMB];
    assign a2 = a[3*LIMB-1:2*LIMB];
    assign b0 = b[LIMB-1:0];
    assign b1 = b[2*LIMB-1:LIMB];
    assign b2 = b[3*LIMB-1:2*LIMB];

    always_comb begin
        req = '0;
        case (idx)
            P_A0B0:   begin req.x = a0;      req.y = b0;      end
            P_A1B1:   begin req.x = a1;      req.y = b1;      end
            P_A2B2:   begin req.x = a2;      req.y = b2;      end
            P_A01B01: begin req.x = a0 ^ a1; req.y = b0 ^ b1; end
            P_A02B02: begin req.x = a0 ^ a2; req.y = b0 ^ b2; end
            P_A12B12: begin req.x = a1 ^ a2; req.y = b1 ^ b2; end
            default:  req = '0;
        endcase
    end
endmodule

// File: rtl/gf81_karatsuba_split.sv
// Front end of the 81-bit Karatsuba multiplier: latches a/b, issues the six
// 3-way Karatsuba limb products to one shared carry-less multiplier and
// collects the returned products into p0..p5.
//   clk, rst_n  clock, async active-low reset
//   bus         gf81_karatsuba_split_if.slave (operands, status, multiplier
//               request/result channels, p0..p5)
// Issue and return run independently, so a pipelined multiplier with up to
// six requests in flight is kept busy every cycle.
module gf81_karatsuba_split
    import gf81_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    gf81_karatsuba_split_if.slave bus
);
    state_t        state_q, state_d;
    logic [2:0]    iss_cnt_q, ret_cnt_q;
    logic [W-1:0]  a_q, b_q;
    logic [PW-1:0] p_q [NPROD];
    logic          accept, mul_valid, issue_hs, capture;
    mul_req_t      sel;

    gf81_limb_sel u_sel (
        .idx (iss_cnt_q),
        .a   (a_q),
        .b   (b_q),
        .req (sel)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        mul_valid = (state_q == RUN) && (iss_cnt_q < CNT_MAX);
        issue_hs  = mul_valid && bus.mul_ready;
        // A result is only taken for a request already issued; this also caps
        // ret_cnt at 6 and drops stray res_valid before the first issue.
        capture   = (state_q == RUN) && bus.res_valid && (ret_cnt_q < iss_cnt_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (capture && (ret_cnt_q == CNT_MAX - 3'd1))
                    state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: x/y are forced to zero while no request is pending so the
    // request channel is quiet outside RUN.
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.mul_valid = mul_valid;
    assign bus.mul_x     = mul_valid ? sel.x : '0;
    assign bus.mul_y     = mul_valid ? sel.y : '0;
    assign bus.p0        = p_q[0];
    assign bus.p1        = p_q[1];
    assign bus.p2        = p_q[2];
    assign bus.p3        = p_q[3];
    assign bus.p4        = p_q[4];
    assign bus.p5        = p_q[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            for (int i = 0; i < NPROD; i++) p_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= bus.a;
                b_q       <= bus.b;
                iss_cnt_q <= '0;
                ret_cnt_q <= '0;
                for (int i = 0; i < NPROD; i++) p_q[i] <= '0;
            end else begin
                if (issue_hs)
                    iss_cnt_q <= iss_cnt_q + 3'd1;
                if (capture) begin
                    ret_cnt_q <= ret_cnt_q + 3'd1;
                    for (int i = 0; i < NPROD; i++)
                        if (ret_cnt_q == 3'(i)) p_q[i] <= bus.res;
                end
            end
        end
    end
endmodule

// File: tb/tb_gf81_karatsuba_split.sv
// Bench for gf81_karatsuba_split: a latency-2 carry-less limb multiplier model
// answers requests; expectations come from limb products per the Karatsuba
// table and a full 81x81 carry-less product.
module tb_gf81_karatsuba_split;
    import gf81_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf81_karatsuba_split_if bus();

    gf81_karatsuba_split dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [52:0] dut_p [6];
    assign dut_p[0] = bus.p0;
    assign dut_p[1] = bus.p1;
    assign dut_p[2] = bus.p2;
    assign dut_p[3] = bus.p3;
    assign dut_p[4] = bus.p4;
    assign dut_p[5] = bus.p5;

    task automatic chk(input string nm, input logic [160:0] act, input logic [160:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [52:0] clmul27(input logic [26:0] x, input logic [26:0] y);
        logic [52:0] r = '0;
        for (int i = 0; i < 27; i++) if (y[i]) r ^= (53'(x) << i);
        return r;
    endfunction

    function automatic logic [160:0] clmul81(input logic [80:0] x, input logic [80:0] y);
        logic [160:0] r = '0;
        for (int i = 0; i < 81; i++) if (y[i]) r ^= (161'(x) << i);
        return r;
    endfunction

    // Expected limb product i from the Karatsuba schedule table.
    function automatic logic [52:0] model_p(input logic [80:0] a, input logic [80:0] b, input int i);
        logic [26:0] al [3];
        logic [26:0] bl [3];
        for (int k = 0; k < 3; k++) begin
            al[k] = a[27*k +: 27];
            bl[k] = b[27*k +: 27];
        end
        case (i)
            0: return clmul27(al[0], bl[0]);
            1: return clmul27(al[1], bl[1]);
            2: return clmul27(al[2], bl[2]);
            3: return clmul27(al[0] ^ al[1], bl[0] ^ bl[1]);
            4: return clmul27(al[0] ^ al[2], bl[0] ^ bl[2]);
            default: return clmul27(al[1] ^ al[2], bl[1] ^ bl[2]);
        endcase
    endfunction

    // 3-way Karatsuba recombination of the six limb products.
    function automatic logic [160:0] recombine(input logic [52:0] p [6]);
        return 161'(p[0])
             ^ (161'(p[3] ^ p[0] ^ p[1]) << 27)
             ^ (161'(p[4] ^ p[0] ^ p[2] ^ p[1]) << 54)
             ^ (161'(p[5] ^ p[1] ^ p[2]) << 81)
             ^ (161'(p[2]) << 108);
    endfunction

    // ---------------- sub-multiplier model (latency 2) ----------------
    logic [52:0] d1, d2;
    bit          d1_v, d2_v;
    int          n_iss, stall_at, stall_left, inj_cyc;

    initial begin
        bus.mul_ready = 1'b1;
        bus.res_valid = 1'b0;
        bus.res       = '0;
        d1 = '0; d2 = '0; d1_v = 0; d2_v = 0;
        n_iss = 0; stall_at = -1; stall_left = 0; inj_cyc = -1;
        forever begin
            @(negedge clk);
            if (d2_v) begin
                bus.res_valid = 1'b1;
                bus.res       = d2;
            end else if (cyc == inj_cyc) begin
                bus.res_valid = 1'b1;
                bus.res       = 53'({$urandom, $urandom}) | 53'd1;
            end else begin
                bus.res_valid = 1'b0;
                bus.res       = 53'({$urandom, $urandom});
            end
            d2_v = d1_v;
            d2   = d1;
            if (stall_left > 0 && n_iss == stall_at && bus.mul_valid) begin
                bus.mul_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mul_ready = 1'b1;
            end
            d1_v = rst_n && bus.mul_valid && bus.mul_ready;
            d1   = clmul27(bus.mul_x, bus.mul_y);
            if (d1_v) n_iss++;
        end
    end

    // ---------------- reference state + compare process ----------------
    logic [80:0] exp_a, exp_b;
    logic [52:0] exp_p [6];
    bit          have_res = 0;
    int          a2_seen = 0;
    logic        prev_v = 1'b0;
    logic [26:0] prev_x = '0, prev_y = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (prev_v && !bus.mul_ready) begin
                    chk("hold_valid", 161'(bus.mul_valid), 161'(1));
                    chk("hold_x", 161'(bus.mul_x), 161'(prev_x));
                    chk("hold_y", 161'(bus.mul_y), 161'(prev_y));
                end
                if (bus.mul_valid && bus.mul_x == exp_a[80:54] && bus.mul_y == exp_b[80:54])
                    a2_seen++;
                if (bus.done) begin
                    for (int i = 0; i < 6; i++)
                        chk($sformatf("done_p%0d", i), 161'(dut_p[i]), 161'(exp_p[i]));
                    chk("recombine", recombine(dut_p), clmul81(exp_a, exp_b));
                end else if (!bus.busy && have_res) begin
                    for (int i = 0; i < 6; i++)
                        chk($sformatf("held_p%0d", i), 161'(dut_p[i]), 161'(exp_p[i]));
                end
            end
            prev_v = bus.mul_valid;
            prev_x = bus.mul_x;
            prev_y = bus.mul_y;
        end
    end

    // Caller sits on a negedge. Returns on the negedge where done is seen.
    task automatic run_op(input logic [80:0] aa, input logic [80:0] bb, input int stall,
                          input int st_at, input int poke, input bit inj, output int lat);
        logic [95:0] r;
        bus.start = 1'b1;
        bus.a     = aa;
        bus.b     = bb;
        exp_a     = aa;
        exp_b     = bb;
        for (int i = 0; i < 6; i++) exp_p[i] = model_p(aa, bb, i);
        have_res   = 0;
        a2_seen    = 0;
        n_iss      = 0;
        stall_at   = st_at;
        stall_left = stall;
        if (inj) inj_cyc = cyc + 1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.start = (k == poke);
            if (k == poke) begin
                r = {$urandom, $urandom, $urandom};
                bus.a = r[80:0];
                r = {$urandom, $urandom, $urandom};
                bus.b = r[80:0];
            end
            chk("busy_run", 161'(bus.busy), 161'(1));
            if (bus.done) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 161'(0), 161'(1));
        have_res = 1;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_busy", 161'(bus.busy), 161'(0));
        chk("idle_done", 161'(bus.done), 161'(0));
        chk("idle_valid", 161'(bus.mul_valid), 161'(0));
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_busy"}, 161'(bus.busy), 161'(0));
        chk({tag, "_done"}, 161'(bus.done), 161'(0));
        chk({tag, "_valid"}, 161'(bus.mul_valid), 161'(0));
        chk({tag, "_x"}, 161'(bus.mul_x), 161'(0));
        chk({tag, "_y"}, 161'(bus.mul_y), 161'(0));
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_p%0d", tag, i), 161'(dut_p[i]), 161'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          ok;
        logic [95:0] r;
        logic [80:0] ra, rb;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        exp_a     = '0;
        exp_b     = '0;
        for (int i = 0; i < 6; i++) exp_p[i] = '0;

        repeat (3) @(negedge clk);
        zero_check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: unit operands, literal pins on the products and latency
        run_op(81'd1, 81'd1, 0, -1, 0, 0, lat);
        chk("s1_lat", 161'(lat), 161'(8));
        chk("s1_p0", 161'(bus.p0), 161'(1));
        chk("s1_p1", 161'(bus.p1), 161'(0));
        chk("s1_p2", 161'(bus.p2), 161'(0));
        chk("s1_p3", 161'(bus.p3), 161'(1));
        chk("s1_p4", 161'(bus.p4), 161'(1));
        chk("s1_p5", 161'(bus.p5), 161'(0));
        idle_check();

        // stray result while idle after done must not disturb p
        inj_cyc = cyc + 1;
        repeat (3) @(negedge clk);

        // 2: single-limb operands
        run_op(81'd1 << 27, 81'd1 << 27, 0, -1, 0, 0, lat);
        chk("s2a_p0", 161'(bus.p0), 161'(0));
        chk("s2a_p1", 161'(bus.p1), 161'(1));
        chk("s2a_p3", 161'(bus.p3), 161'(1));
        chk("s2a_p4", 161'(bus.p4), 161'(0));
        chk("s2a_p5", 161'(bus.p5), 161'(1));
        idle_check();
        run_op(81'd1 << 54, 81'd1 << 54, 0, -1, 0, 0, lat);
        chk("s2b_p2", 161'(bus.p2), 161'(1));
        chk("s2b_p3", 161'(bus.p3), 161'(0));
        chk("s2b_p4", 161'(bus.p4), 161'(1));
        chk("s2b_p5", 161'(bus.p5), 161'(1));
        idle_check();

        // res_valid before any issue is dropped
        run_op({27'h0123456, 27'h2ABCDEF, 27'h7654321}, {27'h5A5A5A5, 27'h0F0F0F0, 27'h3333333},
               0, -1, 0, 1, lat);
        chk("early_res_lat", 161'(lat), 161'(8));
        idle_check();

        // 3: three-cycle stall at issue index 2
        run_op({27'h4000001, 27'h0000002, 27'h0000004}, {27'h2000003, 27'h0000010, 27'h0000020},
               3, 2, 0, 0, lat);
        chk("s3_lat", 161'(lat), 161'(11));
        chk("s3_a2_hold", 161'(a2_seen), 161'(4));
        idle_check();

        // 4: start while busy is ignored; start coincident with done chains
        run_op(81'd1, 81'd1, 0, -1, 3, 0, lat);
        chk("s4_poke_lat", 161'(lat), 161'(8));
        run_op(81'd1 << 27, 81'd3 << 54, 0, -1, 0, 0, lat);
        chk("s4_chain_lat", 161'(lat), 161'(8));
        idle_check();

        // 5: reset after three issues, late results ignored
        bus.start = 1'b1;
        bus.a     = {27'h1111111, 27'h2222222, 27'h3333333};
        bus.b     = {27'h4444444, 27'h5555555, 27'h6666666};
        have_res  = 0;
        n_iss     = 0;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (n_iss >= 3) begin
                ok = 1;
                break;
            end
        end
        chk("s5_reach3", 161'(ok), 161'(1));
        rst_n = 1'b0;
        #1;
        zero_check("s5_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        inj_cyc = cyc + 2;
        repeat (4) @(negedge clk);
        zero_check("s5_after");
        run_op({27'h1111111, 27'h2222222, 27'h3333333}, {27'h4444444, 27'h5555555, 27'h6666666},
               0, -1, 0, 0, lat);
        chk("s5_next_lat", 161'(lat), 161'(8));
        idle_check();

        // 6: random operands, random stalls, random chaining
        for (int n = 0; n < 3000; n++) begin
            int st, sa;
            r  = {$urandom, $urandom, $urandom};
            ra = r[80:0];
            r  = {$urandom, $urandom, $urandom};
            rb = r[80:0];
            st = $urandom_range(0, 2);
            sa = $urandom_range(0, 5);
            run_op(ra, rb, st, sa, 0, 0, lat);
            chk("rand_lat", 161'(lat), 161'(8 + st));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
